// File: rtl/uart_pkg.sv
// Shared UART receive-side types and constants: FSM state encoding,
// oversampling ratio and stop-bit tick counts.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   localparam int OVERSAMPLE = 16;
   localparam int DBIT_DEF   = 8;

   localparam int SB_1   = 16;
   localparam int SB_1P5 = 24;
   localparam int SB_2   = 32;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous idle-high line; 2 clk latency,
// resets to 1 so a reset never looks like a start bit. No backpressure.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver; rx_done_tick one clk after the s_tick that ends the stop count.
// No backpressure: every completed frame overwrites dout/frame_err/parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DBIT       = DBIT_DEF,
   parameter int SB_TICK    = SB_1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            rx_done_tick,
   output logic            frame_err,
   output logic            parity_err
);

   localparam int SW = (SB_TICK > 16) ? 5 : 4;
   localparam int NW = $clog2(DBIT);

   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
   localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
   localparam logic          PAR_ON  = (PARITY_EN != 0);
   localparam logic          PAR_ODD = (PARITY_ODD != 0);

   logic            rx_s;
   state_t          state, state_next;
   logic [SW-1:0]   s, s_next;
   logic [NW-1:0]   n, n_next;
   logic [DBIT-1:0] b, b_next;
   logic            p_err, p_err_next;
   logic [DBIT-1:0] dout_next;
   logic            done_next, frame_err_next, parity_err_next;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rx_s)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         p_err        <= 1'b0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
         parity_err   <= 1'b0;
      end else begin
         state        <= state_next;
         s            <= s_next;
         n            <= n_next;
         b            <= b_next;
         p_err        <= p_err_next;
         dout         <= dout_next;
         rx_done_tick <= done_next;
         frame_err    <= frame_err_next;
         parity_err   <= parity_err_next;
      end
   end

   always_comb begin
      state_next      = state;
      s_next          = s;
      n_next          = n;
      b_next          = b;
      p_err_next      = p_err;
      dout_next       = dout;
      done_next       = 1'b0;
      frame_err_next  = frame_err;
      parity_err_next = parity_err;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               s_next     = '0;
            end
         end
         START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (s_tick) begin
               if (s == S_MID) begin
                  if (!rx_s) begin
                     state_next = DATA;
                     s_next     = '0;
                     n_next     = '0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s == S_END) begin
                  s_next = '0;
                  b_next = {rx_s, b[DBIT-1:1]};
                  if (n == N_LAST) begin
                     state_next = PAR_ON ? PARITY : STOP;
                  end else begin
                     n_next = n + 1'b1;
                  end
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         PARITY: begin
            if (s_tick) begin
               if (s == S_END) begin
                  p_err_next = rx_s ^ (^b) ^ PAR_ODD;
                  s_next     = '0;
                  state_next = STOP;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (s == S_STOP) begin
                  dout_next       = b;
                  frame_err_next  = ~rx_s;
                  parity_err_next = PAR_ON ? p_err : 1'b0;
                  done_next       = 1'b1;
                  s_next          = '0;
                  // A line still low here is a break: report it once, then wait for idle.
                  state_next      = rx_s ? IDLE : BREAK;
               end else begin
                  s_next = s + 1'b1;
               end
            end
         end
         BREAK: begin
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: default, even-parity and two-stop-bit instances.
module tb_uart_rx;

   localparam int TICK_DIV = 4;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic s_tick;
   logic rx_a, rx_b, rx_c;
   logic [7:0] dout_a, dout_b, dout_c;
   logic done_a, done_b, done_c;
   logic fe_a, fe_b, fe_c;
   logic pe_a, pe_b, pe_c;

   exp_t q_a[$], q_b[$], q_c[$];
   int   done_tick_a[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   tick_cnt = 0;

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst(rst), .rx(rx_a), .s_tick(s_tick),
      .dout(dout_a), .rx_done_tick(done_a), .frame_err(fe_a), .parity_err(pe_a)
   );

   uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst(rst), .rx(rx_b), .s_tick(s_tick),
      .dout(dout_b), .rx_done_tick(done_b), .frame_err(fe_b), .parity_err(pe_b)
   );

   uart_rx #(.DBIT(8), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) dut_c (
      .clk(clk), .rst(rst), .rx(rx_c), .s_tick(s_tick),
      .dout(dout_c), .rx_done_tick(done_c), .frame_err(fe_c), .parity_err(pe_c)
   );

   initial forever #5 clk = ~clk;

   initial begin
      int div_cnt;
      div_cnt = 0;
      s_tick  = 1'b0;
      forever begin
         @(negedge clk);
         if (div_cnt == TICK_DIV - 1) begin
            s_tick  = 1'b1;
            div_cnt = 0;
            tick_cnt++;
         end else begin
            s_tick = 1'b0;
            div_cnt++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon(input string name, ref exp_t q[$], input logic [7:0] d,
                      input logic fe, input logic pe);
      exp_t e;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_spurious: got pulse dout=%0h fe=%0b pe=%0b expected no pulse",
                  name, d, fe, pe);
      end else begin
         e = q.pop_front();
         chk({name, "_frame"}, 64'({d, fe, pe}), 64'({e.d, e.fe, e.pe}));
      end
   endtask

   always @(negedge clk) begin
      if (done_a) begin
         done_tick_a.push_back(tick_cnt);
         mon("a", q_a, dout_a, fe_a, pe_a);
      end
      if (done_b) mon("b", q_b, dout_b, fe_b, pe_b);
      if (done_c) mon("c", q_c, dout_c, fe_c, pe_c);
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (!s_tick);
      end
      #1;
   endtask

   task automatic set_rx(input int ch, input logic v);
      case (ch)
         0:       rx_a = v;
         1:       rx_b = v;
         default: rx_c = v;
      endcase
   endtask

   task automatic send_frame(input int ch, input logic [7:0] d, input bit par_on,
                             input logic par, input logic stop_val, input int stop_ticks);
      set_rx(ch, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 8; i++) begin
         set_rx(ch, d[i]);
         wait_ticks(16);
      end
      if (par_on) begin
         set_rx(ch, par);
         wait_ticks(16);
      end
      set_rx(ch, stop_val);
      wait_ticks(stop_ticks);
   endtask

   function automatic exp_t mk(input logic [7:0] d, input logic fe, input logic pe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      e.pe = pe;
      return e;
   endfunction

   initial begin
      logic [7:0] w;
      rst  = 1'b1;
      rx_a = 1'b1;
      rx_b = 1'b1;
      rx_c = 1'b1;
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", 64'({dout_a, done_a, fe_a, pe_a, dout_b, done_b, fe_b, pe_b,
                              dout_c, done_c, fe_c, pe_c}), 64'd0);
      wait_ticks(8);

      q_a.push_back(mk(8'h55, 1'b0, 1'b0));
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 16);
      wait_ticks(40);
      chk("dout_hold", 64'({dout_a, fe_a, pe_a}), 64'({8'h55, 1'b0, 1'b0}));

      set_rx(0, 1'b0);
      wait_ticks(4);
      set_rx(0, 1'b1);
      wait_ticks(40);
      q_a.push_back(mk(8'hC3, 1'b0, 1'b0));
      send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 16);
      wait_ticks(16);

      q_a.push_back(mk(8'hA3, 1'b1, 1'b0));
      send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0, 48);
      set_rx(0, 1'b1);
      wait_ticks(16);
      q_a.push_back(mk(8'h12, 1'b0, 1'b0));
      send_frame(0, 8'h12, 1'b0, 1'b0, 1'b1, 16);
      wait_ticks(16);

      q_b.push_back(mk(8'h07, 1'b0, 1'b0));
      send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 16);
      wait_ticks(16);
      q_b.push_back(mk(8'h07, 1'b0, 1'b1));
      send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, 16);
      wait_ticks(16);

      // Abort 0x3C with a reset in the middle of data bit 4.
      w = 8'h3C;
      set_rx(0, 1'b0);
      wait_ticks(16);
      for (int i = 0; i < 4; i++) begin
         set_rx(0, w[i]);
         wait_ticks(16);
      end
      set_rx(0, w[4]);
      wait_ticks(8);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_frame_reset", 64'({dout_a, done_a, fe_a, pe_a, dout_b, done_b, fe_b, pe_b}),
          64'd0);
      set_rx(0, 1'b1);
      wait_ticks(200);
      q_a.push_back(mk(8'h3C, 1'b0, 1'b0));
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 16);
      wait_ticks(16);

      q_a.push_back(mk(8'h00, 1'b0, 1'b0));
      q_a.push_back(mk(8'hFF, 1'b0, 1'b0));
      send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1, 16);
      send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1, 16);
      if (done_tick_a.size() < 2) begin
         vectors++;
         miscompares++;
         $display("FAIL b2b_spacing: got %0d pulses expected at least 2", done_tick_a.size());
      end else begin
         chk("b2b_spacing", 64'(done_tick_a[done_tick_a.size()-1] -
                                done_tick_a[done_tick_a.size()-2]), 64'd160);
      end
      wait_ticks(16);

      q_c.push_back(mk(8'h81, 1'b0, 1'b0));
      send_frame(2, 8'h81, 1'b0, 1'b0, 1'b1, 32);
      wait_ticks(32);

      chk("pending_a", 64'(q_a.size()), 64'd0);
      chk("pending_b", 64'(q_b.size()), 64'd0);
      chk("pending_c", 64'(q_c.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
